// File: rtl/fft_pkg.sv
// Shared types and helpers for the FFT stage feeder: sample widths, FSM state
// encoding and the twiddle index mapping for a radix-2 DIF stage.
package fft_pkg;

   localparam int unsigned SAMPLE_W = 32;
   localparam int unsigned HALF_W   = 16;

   typedef enum logic [1:0] {
      ST_LOAD  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_GAP   = 2'd2
   } feeder_state_e;

   // W16^power index for butterfly pair idx of an n-point frame
   function automatic logic [2:0] twiddle_power(input logic [3:0] idx, input int unsigned n);
      int unsigned p;
      p = 32'(idx) * (16 / n);
      return p[2:0];
   endfunction

endpackage

// File: rtl/fft_sample_mem.sv
// N x SAMPLE_W frame buffer: one synchronous write port, two asynchronous read
// ports for the upper and lower butterfly operands. Storage is not reset.
module fft_sample_mem
   import fft_pkg::*;
#(
   parameter int unsigned N     = 16,
   parameter int unsigned IDX_W = $clog2(N)
) (
   input  logic                clk,
   input  logic                we,
   input  logic [IDX_W-1:0]    waddr,
   input  logic [SAMPLE_W-1:0] wdata,
   input  logic [IDX_W-1:0]    raddr_a,
   input  logic [IDX_W-1:0]    raddr_b,
   output logic [SAMPLE_W-1:0] rdata_a,
   output logic [SAMPLE_W-1:0] rdata_b
);

   logic [SAMPLE_W-1:0] mem_q [N];

   always_ff @(posedge clk) begin
      if (we) begin
         mem_q[waddr] <= wdata;
      end
   end

   assign rdata_a = mem_q[raddr_a];
   assign rdata_b = mem_q[raddr_b];

endmodule

// File: rtl/fft_stage_feeder.sv
// Frame loader and butterfly-pair issuer for the radix-2 DIF PE.
// Optional macro FFT_FEEDER_OVF_EN adds a sticky ovf output for dropped samples.
module fft_stage_feeder
   import fft_pkg::*;
#(
   parameter int unsigned N         = 16,
   parameter int unsigned ISSUE_GAP = 3
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                in_valid,
   input  logic [SAMPLE_W-1:0] in_data,
   output logic                in_ready,
   output logic [SAMPLE_W-1:0] a,
   output logic [SAMPLE_W-1:0] b,
   output logic [2:0]          power,
   output logic                ab_valid,
   output logic                busy,
   output logic                frame_done
`ifdef FFT_FEEDER_OVF_EN
   ,
   output logic                ovf
`endif
);

   localparam int unsigned IDX_W = $clog2(N);
   localparam int unsigned GAP_W = $clog2(ISSUE_GAP + 1);

   localparam logic [IDX_W-1:0] LAST_WR   = IDX_W'(N - 1);
   localparam logic [IDX_W-1:0] LAST_PAIR = IDX_W'(N / 2 - 1);
   localparam logic [IDX_W-1:0] HALF_OFS  = IDX_W'(N / 2);
   localparam logic [GAP_W-1:0] GAP_INIT  = GAP_W'(ISSUE_GAP - 1);

   feeder_state_e       state_q, state_d;
   logic [IDX_W-1:0]    wr_cnt_q, wr_cnt_d;
   logic [IDX_W-1:0]    pair_cnt_q, pair_cnt_d;
   logic [GAP_W-1:0]    gap_cnt_q, gap_cnt_d;
   logic [SAMPLE_W-1:0] a_q, a_d;
   logic [SAMPLE_W-1:0] b_q, b_d;
   logic [2:0]          power_q, power_d;
   logic                ab_valid_q, ab_valid_d;
   logic                busy_q, busy_d;
   logic                frame_done_q, frame_done_d;
`ifdef FFT_FEEDER_OVF_EN
   logic                ovf_q, ovf_d;
`endif

   logic                mem_we;
   logic [IDX_W-1:0]    idx_b;
   logic [SAMPLE_W-1:0] rd_a, rd_b;

   assign in_ready = (state_q == ST_LOAD);
   assign idx_b    = pair_cnt_q + HALF_OFS;

   fft_sample_mem #(
      .N     (N),
      .IDX_W (IDX_W)
   ) u_mem (
      .clk     (clk),
      .we      (mem_we),
      .waddr   (wr_cnt_q),
      .wdata   (in_data),
      .raddr_a (pair_cnt_q),
      .raddr_b (idx_b),
      .rdata_a (rd_a),
      .rdata_b (rd_b)
   );

   always_comb begin
      state_d      = state_q;
      wr_cnt_d     = wr_cnt_q;
      pair_cnt_d   = pair_cnt_q;
      gap_cnt_d    = gap_cnt_q;
      a_d          = a_q;
      b_d          = b_q;
      power_d      = power_q;
      ab_valid_d   = 1'b0;
      frame_done_d = 1'b0;
      mem_we       = 1'b0;

      case (state_q)
         ST_LOAD: begin
            if (in_valid) begin
               mem_we = 1'b1;
               if (wr_cnt_q == LAST_WR) begin
                  wr_cnt_d = '0;
                  state_d  = ST_ISSUE;
               end else begin
                  wr_cnt_d = wr_cnt_q + IDX_W'(1);
               end
            end
         end
         ST_ISSUE: begin
            a_d        = rd_a;
            b_d        = rd_b;
            power_d    = twiddle_power(4'(pair_cnt_q), N);
            ab_valid_d = 1'b1;
            gap_cnt_d  = GAP_INIT;
            state_d    = ST_GAP;
         end
         ST_GAP: begin
            gap_cnt_d = gap_cnt_q - GAP_W'(1);
            // leaving at gap_cnt==1 makes strobe-to-strobe spacing exactly ISSUE_GAP
            if (gap_cnt_q == GAP_W'(1)) begin
               if (pair_cnt_q < LAST_PAIR) begin
                  pair_cnt_d = pair_cnt_q + IDX_W'(1);
                  state_d    = ST_ISSUE;
               end else begin
                  pair_cnt_d   = '0;
                  frame_done_d = 1'b1;
                  state_d      = ST_LOAD;
               end
            end
         end
         default: begin
            state_d = ST_LOAD;
         end
      endcase

      busy_d = (state_d != ST_LOAD);
`ifdef FFT_FEEDER_OVF_EN
      ovf_d = ovf_q | (in_valid & ~in_ready);
`endif
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= ST_LOAD;
         wr_cnt_q     <= '0;
         pair_cnt_q   <= '0;
         gap_cnt_q    <= '0;
         a_q          <= '0;
         b_q          <= '0;
         power_q      <= '0;
         ab_valid_q   <= 1'b0;
         busy_q       <= 1'b0;
         frame_done_q <= 1'b0;
`ifdef FFT_FEEDER_OVF_EN
         ovf_q        <= 1'b0;
`endif
      end else begin
         state_q      <= state_d;
         wr_cnt_q     <= wr_cnt_d;
         pair_cnt_q   <= pair_cnt_d;
         gap_cnt_q    <= gap_cnt_d;
         a_q          <= a_d;
         b_q          <= b_d;
         power_q      <= power_d;
         ab_valid_q   <= ab_valid_d;
         busy_q       <= busy_d;
         frame_done_q <= frame_done_d;
`ifdef FFT_FEEDER_OVF_EN
         ovf_q        <= ovf_d;
`endif
      end
   end

   assign a          = a_q;
   assign b          = b_q;
   assign power      = power_q;
   assign ab_valid   = ab_valid_q;
   assign busy       = busy_q;
   assign frame_done = frame_done_q;
`ifdef FFT_FEEDER_OVF_EN
   assign ovf        = ovf_q;
`endif

endmodule

// File: tb/tb_fft_stage_feeder.sv
// Directed bench for fft_stage_feeder: N=16 and N=8 instances, stalls, dropped
// samples, mid-frame reset and back-to-back frames against a PE occupancy model.
module tb_fft_stage_feeder;

   localparam int GAP = 3;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        iv16 = 1'b0, iv8 = 1'b0;
   logic [31:0] id16 = '0, id8 = '0;
   logic        rdy16, rdy8, av16, av8, bsy16, bsy8, fd16, fd8;
   logic [31:0] a16, b16, a8, b8;
   logic [2:0]  p16, p8;
`ifdef FFT_FEEDER_OVF_EN
   logic        ovf16, ovf8;
`endif

   always #5 clk = ~clk;

   fft_stage_feeder #(.N(16), .ISSUE_GAP(GAP)) dut16 (
      .clk(clk), .rst(rst), .in_valid(iv16), .in_data(id16), .in_ready(rdy16),
      .a(a16), .b(b16), .power(p16), .ab_valid(av16), .busy(bsy16), .frame_done(fd16)
`ifdef FFT_FEEDER_OVF_EN
      , .ovf(ovf16)
`endif
   );

   fft_stage_feeder #(.N(8), .ISSUE_GAP(GAP)) dut8 (
      .clk(clk), .rst(rst), .in_valid(iv8), .in_data(id8), .in_ready(rdy8),
      .a(a8), .b(b8), .power(p8), .ab_valid(av8), .busy(bsy8), .frame_done(fd8)
`ifdef FFT_FEEDER_OVF_EN
      , .ovf(ovf8)
`endif
   );

   bit          sel = 1'b0;
   logic        s_rdy, s_av, s_bsy, s_fd;
   logic [31:0] s_a, s_b;
   logic [2:0]  s_p;
   assign s_rdy = sel ? rdy8 : rdy16;
   assign s_av  = sel ? av8  : av16;
   assign s_bsy = sel ? bsy8 : bsy16;
   assign s_fd  = sel ? fd8  : fd16;
   assign s_a   = sel ? a8   : a16;
   assign s_b   = sel ? b8   : b16;
   assign s_p   = sel ? p8   : p16;

   int n_checks = 0, n_pass = 0;
   int cyc = 0;
   logic [31:0] frame [16];
   logic [31:0] got_a [16];
   logic [31:0] got_b [16];
   logic [2:0]  got_p [16];
   int          got_t [16];
   int  got_n, done_cyc, busy_cnt, ready_busy, wr_end_cyc;
   bit  tmo, done_ready, load_busy;

   task automatic tick();
      @(posedge clk);
      #1;
      cyc++;
   endtask

   task automatic drive(input logic v, input logic [31:0] d);
      if (sel) begin iv8 = v; id8 = d; end
      else begin iv16 = v; id16 = d; end
   endtask

   task automatic load_frame(input int n, input bit gappy, input bit hold);
      for (int j = 0; j < n; j++) begin
         if (gappy) begin
            drive(1'b0, 32'hDEAD_0000 | 32'(j));
            tick();
         end
         drive(1'b1, frame[j]);
         tick();
      end
      wr_end_cyc = cyc;
      load_busy  = s_bsy;
      if (hold) drive(1'b1, 32'hBAD0_0000);
      else drive(1'b0, '0);
   endtask

   task automatic collect(input int stop_after);
      got_n = 0; done_cyc = -1; busy_cnt = 0; ready_busy = 0; tmo = 1'b1; done_ready = 1'b0;
      for (int t = 0; t < 120; t++) begin
         tick();
         if (s_bsy) busy_cnt++;
         if (s_bsy && s_rdy) ready_busy++;
         if (s_av) begin
            if (got_n < 16) begin
               got_a[got_n] = s_a; got_b[got_n] = s_b; got_p[got_n] = s_p; got_t[got_n] = cyc;
            end
            got_n++;
         end
         if (s_fd) begin
            done_cyc = cyc; done_ready = s_rdy; drive(1'b0, '0); tmo = 1'b0;
            break;
         end
         if (stop_after > 0 && got_n == stop_after) begin
            tmo = 1'b0;
            break;
         end
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      tick(); tick();
      rst = 1'b0;
      tick();
      n_checks++; if (rdy16 !== 1'b1) $display("FAIL rst_in_ready: got %b want 1", rdy16); else n_pass++;
      n_checks++; if (bsy16 !== 1'b0) $display("FAIL rst_busy: got %b want 0", bsy16); else n_pass++;
      n_checks++; if (av16 !== 1'b0) $display("FAIL rst_ab_valid: got %b want 0", av16); else n_pass++;
      n_checks++; if (fd16 !== 1'b0) $display("FAIL rst_frame_done: got %b want 0", fd16); else n_pass++;
      n_checks++; if (a16 !== 32'h0 || b16 !== 32'h0) $display("FAIL rst_ab: got %h/%h want 0/0", a16, b16); else n_pass++;
      n_checks++; if (p16 !== 3'd0) $display("FAIL rst_power: got %0d want 0", p16); else n_pass++;
      n_checks++; if (rdy8 !== 1'b1 || av8 !== 1'b0) $display("FAIL rst_n8: got rdy %b av %b want 1 0", rdy8, av8); else n_pass++;
`ifdef FFT_FEEDER_OVF_EN
      n_checks++; if (ovf16 !== 1'b0) $display("FAIL rst_ovf: got %b want 0", ovf16); else n_pass++;
`endif
   endtask

   task automatic test_n16_frame();
      sel = 1'b0;
      for (int k = 0; k < 16; k++) frame[k] = {16'(k), 16'(16 - k)};
      load_frame(16, 1'b0, 1'b0);
      collect(0);
      n_checks++; if (tmo) $display("FAIL n16_timeout: got timeout want frame_done"); else n_pass++;
      n_checks++; if (got_n !== 8) $display("FAIL n16_count: got %0d want 8", got_n); else n_pass++;
      for (int i = 0; i < 8; i++) begin
         n_checks++;
         if (got_a[i] !== {16'(i), 16'(16 - i)} || got_b[i] !== {16'(i + 8), 16'(8 - i)} || got_p[i] !== 3'(i))
            $display("FAIL n16_pair%0d: got a=%h b=%h p=%0d want a=%h b=%h p=%0d", i, got_a[i], got_b[i], got_p[i],
                     {16'(i), 16'(16 - i)}, {16'(i + 8), 16'(8 - i)}, i);
         else n_pass++;
         if (i > 0) begin
            n_checks++; if (got_t[i] - got_t[i-1] !== GAP) $display("FAIL n16_spacing%0d: got %0d want %0d", i, got_t[i] - got_t[i-1], GAP); else n_pass++;
         end
      end
      n_checks++; if (done_cyc - got_t[7] !== 2) $display("FAIL n16_done_lat: got %0d want 2", done_cyc - got_t[7]); else n_pass++;
      n_checks++; if (done_cyc - wr_end_cyc !== 24) $display("FAIL n16_occupancy: got %0d want 24", done_cyc - wr_end_cyc); else n_pass++;
      n_checks++; if (busy_cnt + int'(load_busy) !== 24) $display("FAIL n16_busy_cycles: got %0d want 24", busy_cnt + int'(load_busy)); else n_pass++;
      n_checks++; if (done_ready !== 1'b1) $display("FAIL n16_ready_at_done: got %b want 1", done_ready); else n_pass++;
   endtask

   task automatic test_n8_frame();
      sel = 1'b1;
      for (int k = 0; k < 8; k++) frame[k] = {16'h0100 + 16'(k), 16'hFF00 + 16'(k)};
      load_frame(8, 1'b0, 1'b0);
      collect(0);
      n_checks++; if (got_n !== 4 || tmo) $display("FAIL n8_count: got %0d (timeout %b) want 4", got_n, tmo); else n_pass++;
      for (int i = 0; i < 4; i++) begin
         n_checks++;
         if (got_a[i] !== {16'h0100 + 16'(i), 16'hFF00 + 16'(i)} || got_b[i] !== {16'h0104 + 16'(i), 16'hFF04 + 16'(i)} || got_p[i] !== 3'(2 * i))
            $display("FAIL n8_pair%0d: got a=%h b=%h p=%0d want p=%0d", i, got_a[i], got_b[i], got_p[i], 2 * i);
         else n_pass++;
      end
      n_checks++; if (done_cyc - wr_end_cyc !== 12) $display("FAIL n8_occupancy: got %0d want 12", done_cyc - wr_end_cyc); else n_pass++;
      sel = 1'b0;
   endtask

   task automatic test_stall();
      sel = 1'b0;
      for (int k = 0; k < 16; k++) frame[k] = {16'h5A00 + 16'(k), 16'(3 * k)};
      load_frame(16, 1'b1, 1'b0);
      collect(0);
      n_checks++; if (got_n !== 8 || tmo) $display("FAIL stall_count: got %0d want 8", got_n); else n_pass++;
      for (int i = 0; i < 8; i += 3) begin
         n_checks++;
         if (got_a[i] !== {16'h5A00 + 16'(i), 16'(3 * i)} || got_b[i] !== {16'h5A08 + 16'(i), 16'(3 * (i + 8))})
            $display("FAIL stall_pair%0d: got a=%h b=%h want a=%h b=%h", i, got_a[i], got_b[i],
                     {16'h5A00 + 16'(i), 16'(3 * i)}, {16'h5A08 + 16'(i), 16'(3 * (i + 8))});
         else n_pass++;
      end
   endtask

   task automatic test_ovf_hold();
      sel = 1'b0;
      for (int k = 0; k < 16; k++) frame[k] = {16'hC000 + 16'(k), 16'h0F00 + 16'(k)};
      load_frame(16, 1'b0, 1'b1);
      collect(0);
      n_checks++; if (got_n !== 8 || tmo) $display("FAIL hold_count: got %0d want 8", got_n); else n_pass++;
      n_checks++; if (ready_busy !== 0) $display("FAIL hold_ready_busy: got %0d want 0", ready_busy); else n_pass++;
      n_checks++;
      if (got_a[7] !== 32'hC007_0F07 || got_b[7] !== 32'hC00F_0F0F)
         $display("FAIL hold_no_write: got a=%h b=%h want a=c0070f07 b=c00f0f0f", got_a[7], got_b[7]);
      else n_pass++;
`ifdef FFT_FEEDER_OVF_EN
      n_checks++; if (ovf16 !== 1'b1) $display("FAIL ovf_set: got %b want 1", ovf16); else n_pass++;
`endif
      for (int k = 0; k < 16; k++) frame[k] = {16'h1234, 16'(k)};
      load_frame(16, 1'b0, 1'b0);
      collect(0);
      n_checks++;
      if (got_n !== 8 || got_a[7] !== 32'h1234_0007 || got_b[7] !== 32'h1234_000F)
         $display("FAIL hold_next_frame: got n=%0d a=%h b=%h want 8 12340007 1234000f", got_n, got_a[7], got_b[7]);
      else n_pass++;
`ifdef FFT_FEEDER_OVF_EN
      n_checks++; if (ovf16 !== 1'b1) $display("FAIL ovf_sticky: got %b want 1", ovf16); else n_pass++;
`endif
   endtask

   task automatic test_reset_mid();
      int strobes, busy_seen;
      sel = 1'b0;
      for (int k = 0; k < 16; k++) frame[k] = {16'h7700 + 16'(k), 16'h0};
      load_frame(16, 1'b0, 1'b0);
      collect(3);
      n_checks++; if (got_n !== 3 || tmo) $display("FAIL mid_pre_strobes: got %0d want 3", got_n); else n_pass++;
      rst = 1'b1;
      #2;
      n_checks++;
      if (av16 !== 1'b0 || bsy16 !== 1'b0 || rdy16 !== 1'b1)
         $display("FAIL mid_rst_outputs: got av=%b busy=%b rdy=%b want 0 0 1", av16, bsy16, rdy16);
      else n_pass++;
      rst = 1'b0;
`ifdef FFT_FEEDER_OVF_EN
      n_checks++; if (ovf16 !== 1'b0) $display("FAIL mid_ovf_clear: got %b want 0", ovf16); else n_pass++;
`endif
      strobes = 0; busy_seen = 0;
      for (int t = 0; t < 30; t++) begin
         tick();
         if (av16) strobes++;
         if (bsy16) busy_seen++;
      end
      n_checks++; if (strobes !== 0 || busy_seen !== 0) $display("FAIL mid_quiet: got strobes=%0d busy=%0d want 0 0", strobes, busy_seen); else n_pass++;
      for (int k = 0; k < 16; k++) frame[k] = {16'h4400 + 16'(k), 16'hAA00 + 16'(k)};
      load_frame(16, 1'b0, 1'b0);
      collect(0);
      n_checks++;
      if (got_n !== 8 || got_p[0] !== 3'd0 || got_a[0] !== 32'h4400_AA00 || got_b[0] !== 32'h4408_AA08)
         $display("FAIL mid_fresh: got n=%0d p=%0d a=%h b=%h want 8 0 4400aa00 4408aa08", got_n, got_p[0], got_a[0], got_b[0]);
      else n_pass++;
   endtask

   task automatic test_back_to_back();
      int last_a, accepted, pe_free;
      sel = 1'b0;
      for (int k = 0; k < 16; k++) frame[k] = {16'h0A00 + 16'(k), 16'(k)};
      load_frame(16, 1'b0, 1'b0);
      collect(0);
      accepted = 0; pe_free = 0;
      for (int i = 0; i < 8 && i < got_n; i++) if (got_t[i] >= pe_free) begin accepted++; pe_free = got_t[i] + GAP; end
      n_checks++; if (accepted !== 8) $display("FAIL b2b_pe_valid_a: got %0d want 8", accepted); else n_pass++;
      last_a = got_t[7];
      for (int k = 0; k < 16; k++) frame[k] = {16'h0B00 + 16'(k), 16'(k)};
      load_frame(16, 1'b0, 1'b0);
      collect(0);
      n_checks++; if (got_t[0] - last_a < GAP) $display("FAIL b2b_overlap: got gap %0d want >= %0d", got_t[0] - last_a, GAP); else n_pass++;
      for (int i = 0; i < 8 && i < got_n; i++) if (got_t[i] >= pe_free) begin accepted++; pe_free = got_t[i] + GAP; end
      n_checks++; if (accepted !== 16 || got_n !== 8) $display("FAIL b2b_pe_valid_b: got %0d total want 16", accepted); else n_pass++;
      n_checks++;
      if (got_a[3] !== 32'h0B03_0003 || got_b[3] !== 32'h0B0B_000B || got_p[3] !== 3'd3)
         $display("FAIL b2b_pair3: got a=%h b=%h p=%0d want 0b030003 0b0b000b 3", got_a[3], got_b[3], got_p[3]);
      else n_pass++;
   endtask

   initial begin
      test_reset();
      test_n16_frame();
      test_n8_frame();
      test_stall();
      test_ovf_hold();
      test_reset_mid();
      test_back_to_back();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
